reorder_returner: RTL and testbench
===================================

REORDER_RETURNER -- requirements
Module: reorder_returner

Interface
REQ-001 Parameter DATA_W, default 16, read data width in bits.
REQ-002 Parameter RD_DEPTH, default 64, read reorder slots; power of two, at least 2.
REQ-003 Parameter WR_DEPTH, default 64, write reorder slots; power of two, at least 2.
REQ-004 Derived widths SHALL be RD_IDX_W = clog2(RD_DEPTH) and WR_IDX_W = clog2(WR_DEPTH).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  completion arriving from back end.
REQ-008 in_type  in  1  completion type (read/write enum from shared package).
REQ-009 in_index  in  max(RD_IDX_W,WR_IDX_W)  issue-order tag; low RD_IDX_W/WR_IDX_W bits used per type.
REQ-010 in_data  in  DATA_W  read data; ignored for writes.
REQ-011 rd_ret_valid / rd_ret_ready  out/in  1/1  in-order read return handshake.
REQ-012 rd_ret_data  out  DATA_W  returned read data.
REQ-013 wr_ret_valid / wr_ret_ready  out/in  1/1  in-order write acknowledge handshake.
REQ-014 dup_err  out  1  one-cycle pulse: completion hit an already-occupied slot.
REQ-015 rd_pending  out  RD_IDX_W+1  occupied read slots plus held read output.

Function
REQ-016 Each type SHALL have a slot array (valid bit, plus DATA_W payload for reads) and a head pointer.
REQ-017 Read and write channels SHALL operate independently and concurrently, one return per channel per cycle.
REQ-018 An output register SHALL load when it is empty or being accepted (valid and ready) in the same cycle, and the head slot is valid or the incoming completion of that type targets head.
REQ-019 On load: head slot cleared, head incremented modulo depth.
REQ-020 Bypass: completion with index equal to head SHALL appear on the output in the next cycle, without occupying the slot.
REQ-021 A completion not consumed by bypass SHALL set its slot's valid bit and store its data.
REQ-022 Output valid and data SHALL hold stable while ready is low.
REQ-023 rd_ret_data SHALL be all zeros whenever rd_ret_valid is low.
REQ-024 Completion arriving at an occupied slot or equal to the index in the held output register SHALL be dropped and SHALL pulse dup_err; existing contents are kept.
REQ-025 Head release and a new completion to a different slot in the same cycle SHALL both take effect.
REQ-026 Head pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-027 rd_pending SHALL update the cycle after each arrival or handshake; simultaneous arrival and handshake SHALL leave it unchanged.

Reset
REQ-028 rst SHALL asynchronously clear all slot valid bits, heads, and rd_pending; rd_ret_valid, wr_ret_valid, rd_ret_data, and dup_err SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all buffered completions; first post-reset expected index is 0 per type.
REQ-030 Outputs SHALL stay 0 during reset regardless of inputs.

Structure
REQ-031 The request-type enum and default depth constants SHALL live in shared package types_def.
REQ-032 One sub-module return_buffer(DEPTH, PAYLOAD_W) SHALL hold slot array, head, bypass and output register; it is instantiated twice (writes with PAYLOAD_W=0 handled by generate).
REQ-033 Top level SHALL hold type demux, dup_err OR and rd_pending counter only.

Verification
REQ-034 Reads with indices 0,1,2 in order, ready=1 -> data returned in cycles N+1..N+3, no dup_err.
REQ-035 Reads with indices 3,2,1 then 0 -> rd_ret_valid rises the cycle after index 0 arrives; data for 0,1,2,3 on four consecutive cycles.
REQ-036 rd_ret_ready low 5 cycles with head ready -> rd_ret_valid and data stable; rd_pending counts arrivals.
REQ-037 Index 5 twice before release -> dup_err one pulse; first data (0xAAAA) returned, second (0x5555) dropped.
REQ-038 RD_DEPTH=4: indices 0..7 interleaved with writes 0..7 -> both channels in order across wrap.
REQ-039 rst pulsed with 3 buffered reads -> outputs 0 immediately; after reset, index 0 returns next cycle.

Source files
------------

// File: rtl/types_def.sv
// ---------------------------------------------------------------------------
// types_def
// Shared definitions for the reorder returner: completion type enum, default
// geometry constants and a small integer helper used for derived widths.
// ---------------------------------------------------------------------------
package types_def;

  // Completion type carried with every back-end response.
  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_RD_DEPTH = 64;
  localparam int DEF_WR_DEPTH = 64;

  // Larger of two integers; sizes the shared completion index port.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/reorder_returner_return_buffer.sv
// ---------------------------------------------------------------------------
// return_buffer
// One reorder channel: a slot array indexed by issue-order tag, a head
// pointer naming the next tag to return, and a one-entry output register.
// A completion for the head tag bypasses the slot array when the output
// register can take it.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid_i      completion for this channel
//   in_index_i      issue-order tag of the completion
//   in_data_i       payload (tied off when PAYLOAD_W is 0)
//   ret_valid_o     output register holds a returnable entry
//   ret_data_o      output payload, zero while ret_valid_o is low
//   ret_ready_i     consumer accepts the output entry
//   dup_o           registered one-cycle pulse: completion was dropped
//   arrive_ok_o     this cycle's completion was accepted (not dropped)
//   ret_fire_o      this cycle's output handshake
// ---------------------------------------------------------------------------
module return_buffer #(
  parameter  int DEPTH     = 64,
  parameter  int PAYLOAD_W = 16,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int DW        = (PAYLOAD_W > 0) ? PAYLOAD_W : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_index_i,
  input  logic [DW-1:0]    in_data_i,
  output logic             ret_valid_o,
  output logic [DW-1:0]    ret_data_o,
  input  logic             ret_ready_i,
  output logic             dup_o,
  output logic             arrive_ok_o,
  output logic             ret_fire_o
);

  logic [DEPTH-1:0] slot_valid_q, slot_valid_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             dup_q, dup_d;

  logic             is_dup_s;
  logic             hit_head_s;
  logic             can_load_s;
  logic             bypass_s;
  logic             store_s;
  logic [DW-1:0]    head_data_s;

  // Payload storage exists only for channels that carry data.
  generate
    if (PAYLOAD_W > 0) begin : g_payload
      logic [DW-1:0] slot_data_q [DEPTH];

      // Payload write when a completion parks in its slot.
      always_ff @(posedge clk) begin
        if (store_s) begin
          slot_data_q[in_index_i] <= in_data_i;
        end
      end

      assign head_data_s = slot_data_q[head_q];
    end else begin : g_no_payload
      assign head_data_s = '0;
    end
  endgenerate

  // Classify the arriving completion and decide load, bypass and store.
  always_comb begin
    slot_valid_d = slot_valid_q;
    head_d       = head_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    dup_d        = 1'b0;
    store_s      = 1'b0;

    // A tag is a duplicate if its slot is full or it is the tag being held
    // in the output register.
    is_dup_s   = in_valid_i &&
                 (slot_valid_q[in_index_i] ||
                  (out_valid_q && (out_idx_q == in_index_i)));
    hit_head_s = in_valid_i && !is_dup_s && (in_index_i == head_q);
    can_load_s = !out_valid_q || ret_ready_i;
    // A head hit can only be fresh when the head slot is empty, so the
    // bypass never competes with a parked head entry.
    bypass_s   = can_load_s && hit_head_s;

    if (is_dup_s) begin
      dup_d = 1'b1;
    end else begin
      dup_d = 1'b0;
    end

    if (can_load_s && (slot_valid_q[head_q] || hit_head_s)) begin
      out_valid_d          = 1'b1;
      out_idx_d            = head_q;
      head_d               = head_q + IDX_W'(1);
      slot_valid_d[head_q] = 1'b0;
      if (slot_valid_q[head_q]) begin
        out_data_d = head_data_s;
      end else begin
        out_data_d = in_data_i;
      end
    end else if (can_load_s) begin
      // Output drained with nothing to replace it: data returns to zero.
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end

    // Park any accepted completion the bypass did not consume. Its slot
    // differs from the head slot released above, so both edits stand.
    if (in_valid_i && !is_dup_s && !bypass_s) begin
      slot_valid_d[in_index_i] = 1'b1;
      store_s                  = 1'b1;
    end else begin
      store_s = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      head_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      dup_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      head_q       <= head_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      dup_q        <= dup_d;
    end
  end

  assign ret_valid_o = out_valid_q;
  assign ret_data_o  = out_data_q;
  assign dup_o       = dup_q;
  assign arrive_ok_o = in_valid_i && !is_dup_s;
  assign ret_fire_o  = out_valid_q && ret_ready_i;

endmodule

// File: rtl/reorder_returner.sv
// ---------------------------------------------------------------------------
// reorder_returner
// Returns out-of-order back-end completions to the requester in issue order,
// with independent read and write channels.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_type/in_index   completion from the back end
//   in_data                     read data (ignored for writes)
//   rd_ret_valid/ready/data     in-order read return
//   wr_ret_valid/ready          in-order write acknowledge
//   dup_err                     one-cycle pulse on a dropped duplicate
//   rd_pending                  read entries buffered or held for return
// ---------------------------------------------------------------------------
module reorder_returner
  import types_def::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int RD_DEPTH = DEF_RD_DEPTH,
  parameter  int WR_DEPTH = DEF_WR_DEPTH,
  localparam int RD_IDX_W = $clog2(RD_DEPTH),
  localparam int WR_IDX_W = $clog2(WR_DEPTH),
  localparam int IN_IDX_W = max_int(RD_IDX_W, WR_IDX_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  req_type_e           in_type,
  input  logic [IN_IDX_W-1:0] in_index,
  input  logic [DATA_W-1:0]   in_data,
  output logic                rd_ret_valid,
  input  logic                rd_ret_ready,
  output logic [DATA_W-1:0]   rd_ret_data,
  output logic                wr_ret_valid,
  input  logic                wr_ret_ready,
  output logic                dup_err,
  output logic [RD_IDX_W:0]   rd_pending
);

  logic              rd_in_valid_s;
  logic              wr_in_valid_s;
  logic              rd_dup_s;
  logic              wr_dup_s;
  logic              rd_arrive_s;
  logic              rd_fire_s;
  logic              wr_arrive_s;
  logic              wr_fire_s;
  logic [0:0]        wr_ret_data_s;
  logic [RD_IDX_W:0] rd_pending_q, rd_pending_d;

  // Route the completion to the channel named by its type.
  always_comb begin
    rd_in_valid_s = 1'b0;
    wr_in_valid_s = 1'b0;
    case (in_type)
      REQ_RD:  rd_in_valid_s = in_valid;
      REQ_WR:  wr_in_valid_s = in_valid;
      default: begin
        rd_in_valid_s = 1'b0;
        wr_in_valid_s = 1'b0;
      end
    endcase
  end

  return_buffer #(
    .DEPTH     (RD_DEPTH),
    .PAYLOAD_W (DATA_W)
  ) u_rd_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_in_valid_s),
    .in_index_i  (in_index[RD_IDX_W-1:0]),
    .in_data_i   (in_data),
    .ret_valid_o (rd_ret_valid),
    .ret_data_o  (rd_ret_data),
    .ret_ready_i (rd_ret_ready),
    .dup_o       (rd_dup_s),
    .arrive_ok_o (rd_arrive_s),
    .ret_fire_o  (rd_fire_s)
  );

  return_buffer #(
    .DEPTH     (WR_DEPTH),
    .PAYLOAD_W (0)
  ) u_wr_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (wr_in_valid_s),
    .in_index_i  (in_index[WR_IDX_W-1:0]),
    .in_data_i   (1'b0),
    .ret_valid_o (wr_ret_valid),
    .ret_data_o  (wr_ret_data_s),
    .ret_ready_i (wr_ret_ready),
    .dup_o       (wr_dup_s),
    .arrive_ok_o (wr_arrive_s),
    .ret_fire_o  (wr_fire_s)
  );

  // Read occupancy: accepted arrivals add one, handshakes remove one.
  always_comb begin
    rd_pending_d = rd_pending_q;
    case ({rd_arrive_s, rd_fire_s})
      2'b10:   rd_pending_d = rd_pending_q + (RD_IDX_W+1)'(1);
      2'b01:   rd_pending_d = rd_pending_q - (RD_IDX_W+1)'(1);
      default: rd_pending_d = rd_pending_q;
    endcase
  end

  // Read occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  // Both duplicate pulses are already registered inside the channels.
  assign dup_err    = rd_dup_s | wr_dup_s;
  assign rd_pending = rd_pending_q;

endmodule

// File: tb/tb_reorder_returner.sv
module tb_reorder_returner;
  import types_def::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  req_type_e   in_type;
  logic [5:0]  in_index;
  logic [15:0] in_data;
  logic        rd_ready;
  logic        wr_ready;

  logic        rd_valid, wr_valid, dup;
  logic [15:0] rd_data;
  logic [6:0]  pend;

  logic        rd4_valid, wr4_valid, dup4;
  logic [15:0] rd4_data;
  logic [2:0]  pend4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reorder_returner u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_type      (in_type),
    .in_index     (in_index),
    .in_data      (in_data),
    .rd_ret_valid (rd_valid),
    .rd_ret_ready (rd_ready),
    .rd_ret_data  (rd_data),
    .wr_ret_valid (wr_valid),
    .wr_ret_ready (wr_ready),
    .dup_err      (dup),
    .rd_pending   (pend)
  );

  reorder_returner #(.RD_DEPTH(4), .WR_DEPTH(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_type      (in_type),
    .in_index     (in_index[1:0]),
    .in_data      (in_data),
    .rd_ret_valid (rd4_valid),
    .rd_ret_ready (rd_ready),
    .rd_ret_data  (rd4_data),
    .wr_ret_valid (wr4_valid),
    .wr_ret_ready (wr_ready),
    .dup_err      (dup4),
    .rd_pending   (pend4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input req_type_e t, input int idx, input logic [15:0] d);
    in_valid = 1'b1;
    in_type  = t;
    in_index = idx[5:0];
    in_data  = d;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 16'h0000;
    step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int ord [8] = '{1, 0, 3, 2, 5, 4, 7, 6};
  int rk;
  int wk;

  task automatic mon4();
    check_val("wrap_dup", {31'd0, dup4}, 32'd0);
    if (rd4_valid) begin
      check_val("wrap_rd_data", {16'd0, rd4_data}, 32'h5000 + rk);
      rk++;
    end
    if (wr4_valid) begin
      wk++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_type  = REQ_RD;
    in_index = 6'd0;
    in_data  = 16'h0000;
    rd_ready = 1'b1;
    wr_ready = 1'b1;
    step();
    check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_val("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check_val("rst_dup", {31'd0, dup}, 32'd0);
    check_val("rst_pend", {25'd0, pend}, 32'd0);
    rst = 1'b0;

    // In-order reads bypass straight to the output.
    for (int i = 0; i < 3; i++) begin
      send(REQ_RD, i, 16'h1000 + 16'(i));
      check_val("inord_valid", {31'd0, rd_valid}, 32'd1);
      check_val("inord_data", {16'd0, rd_data}, 32'h1000 + i);
      check_val("inord_dup", {31'd0, dup}, 32'd0);
      check_val("inord_pend", {25'd0, pend}, 32'd1);
    end
    idle();
    check_val("inord_drain_valid", {31'd0, rd_valid}, 32'd0);
    check_val("inord_drain_data", {16'd0, rd_data}, 32'd0);
    check_val("inord_drain_pend", {25'd0, pend}, 32'd0);

    // Reverse order 3,2,1 then 0.
    do_reset();
    for (int i = 3; i > 0; i--) begin
      send(REQ_RD, i, 16'h2000 + 16'(i));
      check_val("rev_hold_valid", {31'd0, rd_valid}, 32'd0);
    end
    check_val("rev_pend", {25'd0, pend}, 32'd3);
    send(REQ_RD, 0, 16'h2000);
    check_val("rev_valid0", {31'd0, rd_valid}, 32'd1);
    check_val("rev_data0", {16'd0, rd_data}, 32'h2000);
    for (int i = 1; i < 4; i++) begin
      idle();
      check_val("rev_valid", {31'd0, rd_valid}, 32'd1);
      check_val("rev_data", {16'd0, rd_data}, 32'h2000 + i);
    end
    idle();
    check_val("rev_end_valid", {31'd0, rd_valid}, 32'd0);

    // Back-pressure: output holds while arrivals accumulate.
    do_reset();
    rd_ready = 1'b0;
    send(REQ_RD, 0, 16'h3000);
    check_val("bp_pend0", {25'd0, pend}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      send(REQ_RD, i, 16'h3000 + 16'(i));
      check_val("bp_valid", {31'd0, rd_valid}, 32'd1);
      check_val("bp_data", {16'd0, rd_data}, 32'h3000);
      check_val("bp_pend", {25'd0, pend}, 32'd1 + i);
    end
    idle();
    check_val("bp_idle_data", {16'd0, rd_data}, 32'h3000);
    check_val("bp_idle_pend", {25'd0, pend}, 32'd5);
    rd_ready = 1'b1;
    idle();
    check_val("bp_next_data", {16'd0, rd_data}, 32'h3001);
    check_val("bp_next_pend", {25'd0, pend}, 32'd4);

    // Duplicate to an occupied slot.
    do_reset();
    rd_ready = 1'b0;
    send(REQ_RD, 5, 16'hAAAA);
    check_val("dup_first", {31'd0, dup}, 32'd0);
    send(REQ_RD, 5, 16'h5555);
    check_val("dup_pulse", {31'd0, dup}, 32'd1);
    check_val("dup_pend", {25'd0, pend}, 32'd1);
    idle();
    check_val("dup_one_cycle", {31'd0, dup}, 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(REQ_RD, i, 16'h4000 + 16'(i));
      check_val("dup_fill_data", {16'd0, rd_data}, 32'h4000 + i);
    end
    idle();
    check_val("dup_kept_data", {16'd0, rd_data}, 32'hAAAA);
    idle();
    check_val("dup_end_valid", {31'd0, rd_valid}, 32'd0);
    check_val("dup_end_pend", {25'd0, pend}, 32'd0);

    // Duplicate of the tag held in the output register.
    do_reset();
    rd_ready = 1'b0;
    send(REQ_RD, 0, 16'h1111);
    send(REQ_RD, 0, 16'h2222);
    check_val("duphold_pulse", {31'd0, dup}, 32'd1);
    check_val("duphold_data", {16'd0, rd_data}, 32'h1111);
    check_val("duphold_pend", {25'd0, pend}, 32'd1);
    rd_ready = 1'b1;

    // Depth-4 wrap with interleaved reads and writes.
    do_reset();
    rk = 0;
    wk = 0;
    for (int i = 0; i < 8; i++) begin
      send(REQ_RD, ord[i], 16'h5000 + 16'(ord[i]));
      mon4();
      send(REQ_WR, ord[i], 16'h0000);
      mon4();
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      mon4();
    end
    check_val("wrap_rd_count", rk, 32'd8);
    check_val("wrap_wr_count", wk, 32'd8);
    check_val("wrap_pend", {29'd0, pend4}, 32'd0);

    // Mid-operation reset.
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(REQ_RD, i, 16'h6100 + 16'(i));
    end
    check_val("mrst_pre_pend", {25'd0, pend}, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check_val("mrst_valid", {31'd0, rd_valid}, 32'd0);
    check_val("mrst_data", {16'd0, rd_data}, 32'd0);
    check_val("mrst_pend", {25'd0, pend}, 32'd0);
    in_valid = 1'b1;
    in_type  = REQ_RD;
    in_index = 6'd0;
    in_data  = 16'h7777;
    step();
    check_val("mrst_hold_valid", {31'd0, rd_valid}, 32'd0);
    check_val("mrst_hold_data", {16'd0, rd_data}, 32'd0);
    rst      = 1'b0;
    rd_ready = 1'b1;
    send(REQ_RD, 0, 16'h6000);
    check_val("mrst_first_valid", {31'd0, rd_valid}, 32'd1);
    check_val("mrst_first_data", {16'd0, rd_data}, 32'h6000);
    check_val("mrst_first_dup", {31'd0, dup}, 32'd0);
    idle();
    check_val("mrst_discard", {31'd0, rd_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
